map_switch_ctrl: RTL and testbench
==================================

MAP_SWITCH_CTRL -- requirements
Module: map_switch_ctrl

Interface
REQ-001 Parameter QUIESCE_CYC, default 16: clk cycles map_rst is held before the new index is committed.
REQ-002 Parameter SETTLE_CYC, default 4: clk cycles map_rst stays asserted after commit.
REQ-003 Parameter DRAIN_TMO, default 255: max clk cycles spent waiting for an M2 falling edge.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  switch request, level; a rising edge starts a switch.
REQ-007 req_idx  in  8  requested mapper number; sampled on the accepted req edge.
REQ-008 m2  in  1  cartridge M2 (CPU phi2), asynchronous to clk.
REQ-009 busy  out  1  high from accept until the ack cycle inclusive.
REQ-010 ack  out  1  one-cycle completion pulse.
REQ-011 err  out  1  sticky drain-timeout flag; cleared on next accepted request.
REQ-012 map_idx  out  8  committed mapper number, drives mapper hub select.
REQ-013 map_slot  out  3  registered hub slot for map_idx.
REQ-014 map_rst  out  1  active-high hold-in-reset to all mapper instances; also forces cartridge data outputs off.

Function
REQ-015 m2 shall pass a 2-flop synchronizer (reset 0); M2 falling edge = synced value 1 in previous cycle, 0 in current.
REQ-016 req edge detect: req registered (reset 0); accepted only in IDLE when req=1 and registered req=0.
REQ-017 States: IDLE, DRAIN, QUIESCE, COMMIT, RELEASE, ACK.
REQ-018 IDLE: on accepted edge, latch req_idx into pend_idx, clear err, busy=1; go ACK if req_idx==map_idx, else DRAIN.
REQ-019 DRAIN: wait for M2 falling edge -> QUIESCE; if DRAIN_TMO cycles elapse without one, set err=1 and go QUIESCE.
REQ-020 QUIESCE: map_rst=1 from first QUIESCE cycle; stay exactly QUIESCE_CYC cycles, then COMMIT.
REQ-021 COMMIT (1 cycle): map_idx<=pend_idx, map_slot<=slot(pend_idx); map_rst stays 1; go RELEASE.
REQ-022 RELEASE: map_rst=1 for exactly SETTLE_CYC cycles, then map_rst=0 and go ACK.
REQ-023 ACK (1 cycle): ack=1, busy=1; next cycle IDLE with busy=0, ack=0.
REQ-024 slot(): 79,113,146->1; 90,211->2; 133->3; 137,138,139,141->4; 147->5; 148->6; 150,243->7; any other->0 (nominal).
REQ-025 map_idx and map_slot shall change only in COMMIT and reset; never glitch mid-switch.
REQ-026 req edges while busy=1 shall be ignored and not queued; req held high through ACK shall not retrigger.
REQ-027 Same-index request: no map_rst assertion, ack exactly 2 cycles after req edge sampled.
REQ-028 Counters sized to hold max(QUIESCE_CYC,SETTLE_CYC,DRAIN_TMO); no wrap within a state.
REQ-029 m2 stopped (no edges) shall not hang the block; DRAIN_TMO bounds it.

Reset
REQ-030 rst_n low: state=RELEASE-startup, map_idx=0, map_slot=0, map_rst=1, busy=1, ack=0, err=0, synchronizer/req regs=0.
REQ-031 After rst_n release: map_rst held SETTLE_CYC cycles, then one ACK cycle with ack=0 (startup ack suppressed), then IDLE, busy=0.
REQ-032 rst_n assertion mid-switch shall abort immediately to reset values; pend_idx discarded.

Verification
REQ-033 Reset release, no req -> map_rst=1 for 4 cycles, busy low by cycle 6, map_idx=0, ack never pulses.
REQ-034 req edge, req_idx=138, m2 toggling -> map_rst rises after M2 fall, 16 cycles later map_idx=138/map_slot=4, map_rst low 4 cycles later, one ack pulse.
REQ-035 m2 held 0, req_idx=243 -> err=1 after 255 DRAIN cycles, switch completes with map_slot=7, err stays 1 until next accepted req.
REQ-036 req_idx=0x00 while map_idx=0 -> ack 2 cycles after edge, map_rst never asserted.
REQ-037 Second req edge during QUIESCE with req_idx=90 -> ignored; map_idx ends at first index; req_idx=200 request -> map_slot=0.
REQ-038 rst_n pulsed low during QUIESCE -> outputs at reset values asynchronously, map_idx=0, startup sequence repeats.

Source files
------------

// File: rtl/map_switch_ctrl.sv
// map_switch_ctrl
//   Sequences a mapper switch for the cartridge hub. A rising edge on req
//   starts a switch. The block waits for a falling edge of the cartridge M2
//   clock (so the CPU bus is between cycles), holds every mapper in reset
//   while the new index is committed, lets the mappers settle, then pulses
//   ack. Requesting the index that is already active completes right away
//   without touching map_rst.
//
// Parameters
//   QUIESCE_CYC  cycles map_rst is held before the new index is committed
//   SETTLE_CYC   cycles map_rst stays asserted after the commit
//   DRAIN_TMO    upper bound on cycles spent waiting for an M2 falling edge
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   req       switch request (level, rising edge starts a switch)
//   req_idx   requested mapper number, sampled on the accepted req edge
//   m2        cartridge M2 (CPU phi2), asynchronous to clk
//   busy      high from accept through the ack cycle
//   ack       one-cycle completion pulse
//   err       sticky drain-timeout flag, cleared by the next accepted request
//   map_idx   committed mapper number (hub select)
//   map_slot  registered hub slot for map_idx
//   map_rst   hold-in-reset to all mappers, also gates cartridge data outputs

module map_switch_ctrl #(
  parameter int QUIESCE_CYC = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int DRAIN_TMO   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] req_idx,
  input  logic       m2,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] map_idx,
  output logic [2:0] map_slot,
  output logic       map_rst
);

  localparam int CNT_MAX_QS = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
  localparam int CNT_MAX    = (CNT_MAX_QS > DRAIN_TMO) ? CNT_MAX_QS : DRAIN_TMO;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TMO - 1);
  localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, DRAIN, QUIESCE, COMMIT, RELEASE, ACK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       pend_idx;
  logic             startup;
  logic             req_q;
  logic             m2_meta, m2_sync, m2_last;
  logic             m2_fall;
  logic             accept, timeout, commit;

  // Hub slot table; unlisted mapper numbers fall back to the nominal slot 0.
  function automatic logic [2:0] slot_of(input logic [7:0] idx);
    case (idx)
      8'd79, 8'd113, 8'd146:            slot_of = 3'd1;
      8'd90, 8'd211:                    slot_of = 3'd2;
      8'd133:                           slot_of = 3'd3;
      8'd137, 8'd138, 8'd139, 8'd141:   slot_of = 3'd4;
      8'd147:                           slot_of = 3'd5;
      8'd148:                           slot_of = 3'd6;
      8'd150, 8'd243:                   slot_of = 3'd7;
      default:                          slot_of = 3'd0;
    endcase
  endfunction

  // M2 synchronizer plus one extra stage to see the synced value's history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta <= 1'b0;
      m2_sync <= 1'b0;
      m2_last <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      m2_meta <= m2;
      m2_sync <= m2_meta;
      m2_last <= m2_sync;
      req_q   <= req;
    end
  end

  assign m2_fall = m2_last & ~m2_sync;

  // Reset parks the FSM in RELEASE so the mappers get their settle time
  // after power-up; the startup flag hides the ack of that first pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RELEASE;
      cnt      <= '0;
      startup  <= 1'b1;
      pend_idx <= 8'd0;
      map_idx  <= 8'd0;
      map_slot <= 3'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ACK) begin
        startup <= 1'b0;
      end
      if (accept) begin
        pend_idx <= req_idx;
        err      <= 1'b0;
      end
      if (timeout) begin
        err <= 1'b1;
      end
      if (commit) begin
        map_idx  <= pend_idx;
        map_slot <= slot_of(pend_idx);
      end
    end
  end

  // Next state and Moore outputs. busy also rises combinationally in the
  // accepting IDLE cycle so the requester sees it from the edge on.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    accept    = 1'b0;
    timeout   = 1'b0;
    commit    = 1'b0;
    busy      = 1'b1;
    ack       = 1'b0;
    map_rst   = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (req && !req_q) begin
          accept    = 1'b1;
          busy      = 1'b1;
          state_nxt = (req_idx == map_idx) ? ACK : DRAIN;
        end
      end
      DRAIN: begin
        if (m2_fall) begin
          state_nxt = QUIESCE;
          cnt_nxt   = '0;
        end else if (cnt == DRAIN_LAST) begin
          timeout   = 1'b1;
          state_nxt = QUIESCE;
          cnt_nxt   = '0;
        end
      end
      QUIESCE: begin
        map_rst = 1'b1;
        if (cnt == QUIESCE_LAST) begin
          state_nxt = COMMIT;
          cnt_nxt   = '0;
        end
      end
      COMMIT: begin
        map_rst   = 1'b1;
        commit    = 1'b1;
        state_nxt = RELEASE;
        cnt_nxt   = '0;
      end
      RELEASE: begin
        map_rst = 1'b1;
        if (cnt == SETTLE_LAST) begin
          state_nxt = ACK;
          cnt_nxt   = '0;
        end
      end
      ACK: begin
        ack       = ~startup;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_map_switch_ctrl.sv
// tb_map_switch_ctrl
//   Self-checking bench for map_switch_ctrl. A timeline model predicts, for
//   every clock edge, the window in which map_rst is high, when ack fires,
//   when busy drops and when the committed index changes. Directed scenarios
//   cover startup, a normal switch, drain timeout, same-index requests,
//   requests during a switch, an unlisted index and an asynchronous reset in
//   the middle of a switch; a randomized phase follows.

module tb_map_switch_ctrl;

  localparam int Q   = 16;
  localparam int S   = 4;
  localparam int T   = 255;
  localparam int BIG = 1000000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] req_idx;
  logic       m2;
  logic       busy;
  logic       ack;
  logic       err;
  logic [7:0] map_idx;
  logic [2:0] map_slot;
  logic       map_rst;

  int checks;
  int errors;
  int ack_count;

  // Timeline model state: n counts clock edges; the other edge numbers mark
  // where the current request's phases begin and end.
  int         n;
  int         acc_edge;
  int         q_start;
  int         commit_edge;
  int         ack_edge;
  bit         draining;
  bit         startup;
  bit         m_err;
  logic [7:0] m_idx;
  logic [2:0] m_slot;
  logic [7:0] pend;
  bit         prev_req;
  bit         p1, p2, p3;

  logic [7:0] interesting [0:15] = '{8'd79, 8'd113, 8'd146, 8'd90, 8'd211, 8'd133,
                                     8'd137, 8'd138, 8'd139, 8'd141, 8'd147, 8'd148,
                                     8'd150, 8'd243, 8'd0, 8'd200};

  always #5 clk = ~clk;

  map_switch_ctrl #(
    .QUIESCE_CYC(Q),
    .SETTLE_CYC (S),
    .DRAIN_TMO  (T)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_idx (req_idx),
    .m2      (m2),
    .busy    (busy),
    .ack     (ack),
    .err     (err),
    .map_idx (map_idx),
    .map_slot(map_slot),
    .map_rst (map_rst)
  );

  function automatic logic [2:0] ref_slot(input logic [7:0] idx);
    case (idx)
      8'd79, 8'd113, 8'd146:          ref_slot = 3'd1;
      8'd90, 8'd211:                  ref_slot = 3'd2;
      8'd133:                         ref_slot = 3'd3;
      8'd137, 8'd138, 8'd139, 8'd141: ref_slot = 3'd4;
      8'd147:                         ref_slot = 3'd5;
      8'd148:                         ref_slot = 3'd6;
      8'd150, 8'd243:                 ref_slot = 3'd7;
      default:                        ref_slot = 3'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] idx, input logic mm);
    req     = r;
    req_idx = idx;
    m2      = mm;
  endtask

  task automatic resetModel();
    draining    = 1'b0;
    startup     = 1'b1;
    q_start     = 0;
    ack_edge    = BIG;
    commit_edge = -1;
    m_idx       = 8'd0;
    m_slot      = 3'd0;
    m_err       = 1'b0;
    pend        = 8'd0;
    prev_req    = 1'b0;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
  endtask

  // Reset released now: settle window ends four edges later, startup ack hidden.
  task automatic releaseReset();
    rst_n    = 1'b1;
    ack_edge = n + 1 + S - 1;
  endtask

  // Advance the model by one clock edge using the inputs as they were driven.
  task automatic modelEdge();
    bit fall;
    n++;
    if (!rst_n) begin
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
      prev_req = 1'b0;
      return;
    end
    // M2 reaches the clock domain two edges late; a fall is seen as 1 then 0.
    fall = p3 & ~p2;
    if (draining) begin
      if (fall || (n - acc_edge) == T) begin
        if (!fall) m_err = 1'b1;
        draining    = 1'b0;
        q_start     = n;
        commit_edge = n + Q + 1;
        ack_edge    = n + Q + 1 + S;
      end
    end
    if (n == commit_edge) begin
      m_idx  = pend;
      m_slot = ref_slot(pend);
    end
    if (!draining && n >= ack_edge + 2 && req && !prev_req) begin
      acc_edge    = n;
      m_err       = 1'b0;
      startup     = 1'b0;
      pend        = req_idx;
      commit_edge = -1;
      q_start     = BIG;
      if (req_idx == m_idx) begin
        ack_edge = n;
      end else begin
        draining = 1'b1;
        ack_edge = BIG;
      end
    end
    prev_req = req;
    p3 = p2;
    p2 = p1;
    p1 = m2;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("busy",     busy,     (n <= ack_edge));
    checkOutput("ack",      ack,      ((n == ack_edge) && !startup));
    checkOutput("map_rst",  map_rst,  ((n >= q_start) && (n < ack_edge)));
    checkOutput("err",      err,      m_err);
    checkOutput("map_idx",  map_idx,  m_idx);
    checkOutput("map_slot", map_slot, m_slot);
    if (ack === 1'b1) ack_count++;
  endtask

  function automatic logic [7:0] pickIdx();
    if ($urandom_range(0, 3) != 0) return interesting[$urandom_range(0, 15)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bit stuck;
    logic cur_req;
    checks    = 0;
    errors    = 0;
    ack_count = 0;
    n         = 0;
    acc_edge  = 0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    resetModel();

    $display("[TB] startup sequence");
    repeat (3) tick();
    releaseReset();
    repeat (8) tick();
    checkOutput("startup_ack_count", ack_count, 0);
    checkOutput("startup_busy_low", busy, 0);

    $display("[TB] switch to 138 with M2 running");
    ack_count = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 8'd138, 1'($urandom_range(0, 1)));
      tick();
    end
    checkOutput("sw138_idx", map_idx, 138);
    checkOutput("sw138_slot", map_slot, 4);
    checkOutput("sw138_ack_count", ack_count, 1);

    $display("[TB] switch to 243 with M2 stopped");
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b1, 8'd243, 1'b0);
    repeat (300) tick();
    checkOutput("tmo_err", err, 1);
    checkOutput("tmo_slot", map_slot, 7);
    applyStimulus(1'b0, 8'd5, 1'b0);
    repeat (5) tick();
    checkOutput("tmo_err_sticky", err, 1);

    $display("[TB] same-index request");
    ack_count = 0;
    applyStimulus(1'b1, 8'd243, 1'b1);
    tick();
    checkOutput("same_ack", ack, 1);
    checkOutput("same_err_cleared", err, 0);
    repeat (6) tick();
    checkOutput("same_ack_count", ack_count, 1);

    $display("[TB] second request during QUIESCE");
    applyStimulus(1'b0, 8'd0, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 8'd147, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd147, 1'b0);
    repeat (7) tick();
    checkOutput("q_map_rst", map_rst, 1);
    applyStimulus(1'b0, 8'd90, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd90, 1'b1);
    repeat (40) tick();
    checkOutput("q_idx_first", map_idx, 147);
    checkOutput("q_slot_first", map_slot, 5);

    $display("[TB] unlisted index 200");
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 8'd200, 1'($urandom_range(0, 1)));
      tick();
    end
    checkOutput("u200_slot", map_slot, 0);
    checkOutput("u200_idx", map_idx, 200);

    $display("[TB] reset during QUIESCE");
    applyStimulus(1'b0, 8'd0, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 8'd79, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd79, 1'b0);
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_map_rst", map_rst, 1);
    checkOutput("arst_busy", busy, 1);
    checkOutput("arst_ack", ack, 0);
    checkOutput("arst_err", err, 0);
    checkOutput("arst_idx", map_idx, 0);
    checkOutput("arst_slot", map_slot, 0);
    resetModel();
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (2) tick();
    releaseReset();
    ack_count = 0;
    repeat (8) tick();
    checkOutput("rstart_ack_count", ack_count, 0);

    $display("[TB] index 0 while map_idx is 0");
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    checkOutput("zero_ack", ack, 1);
    checkOutput("zero_map_rst", map_rst, 0);
    repeat (3) tick();

    $display("[TB] randomized phase");
    stuck   = 1'b0;
    cur_req = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) stuck = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) cur_req = ~cur_req;
      applyStimulus(cur_req, pickIdx(), stuck ? 1'b0 : 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
